// File: rtl/bcd_updown_counter_if.sv
// Counter control and readout bundle: the event/host side drives the strobes,
// the counter drives the live count, the snapshot and the status pulses.
interface bcd_updown_counter_if #(
  parameter int unsigned DIGITS = 8
);
  localparam int unsigned W = 4 * DIGITS;

  logic         en;
  logic         dir;
  logic         load;
  logic [W-1:0] load_val;
  logic         upd;
  logic [W-1:0] count;
  logic [W-1:0] snap;
  logic         carry;
  logic         load_err;

  modport master (
    output en, dir, load, load_val, upd,
    input  count, snap, carry, load_err
  );

  modport slave (
    input  en, dir, load, load_val, upd,
    output count, snap, carry, load_err
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with validated parallel load, wrap or
// saturate at the boundary, carry/borrow pulse and a snapshot register.
module bcd_updown_counter #(
  parameter int unsigned DIGITS = 8,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_updown_counter_if.slave   bus
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0]             count_q, count_d;
  logic [W-1:0]             snap_q, snap_d;
  logic                     carry_q, carry_d;
  logic                     err_q, err_d;

  logic [DIGITS-1:0][3:0]   cur;
  logic [DIGITS-1:0][3:0]   lv;
  logic [DIGITS-1:0][3:0]   step_up;
  logic [DIGITS-1:0][3:0]   step_dn;
  logic [DIGITS-1:0]        is9;
  logic [DIGITS-1:0]        is0;
  logic [DIGITS-1:0]        lv_ok;
  logic [DIGITS-1:0]        up_en;
  logic [DIGITS-1:0]        dn_en;
  logic                     at_max;
  logic                     at_zero;
  logic                     boundary;
  logic                     lv_valid;

  assign cur = count_q;
  assign lv  = bus.load_val;

  // Per-digit terminal detect and load-value validity.
  always_comb begin
    is9   = '0;
    is0   = '0;
    lv_ok = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      is9[i]   = (cur[i] == 4'd9);
      is0[i]   = (cur[i] == 4'd0);
      lv_ok[i] = (lv[i] <= 4'd9);
    end
  end

  // Ripple-enable chains: a digit steps only when every lower digit is terminal.
  always_comb begin
    logic run_up;
    logic run_dn;
    up_en  = '0;
    dn_en  = '0;
    run_up = 1'b1;
    run_dn = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      up_en[i] = run_up;
      dn_en[i] = run_dn;
      run_up   = run_up & is9[i];
      run_dn   = run_dn & is0[i];
    end
  end

  // Candidate next values for a step in either direction.
  always_comb begin
    step_up = cur;
    step_dn = cur;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (up_en[i]) begin
        step_up[i] = is9[i] ? 4'd0 : 4'(cur[i] + 4'd1);
      end
      if (dn_en[i]) begin
        step_dn[i] = is0[i] ? 4'd9 : 4'(cur[i] - 4'd1);
      end
    end
  end

  assign at_max   = &is9;
  assign at_zero  = &is0;
  assign lv_valid = &lv_ok;
  assign boundary = bus.dir ? at_max : at_zero;

  // Next-state: load has priority over counting; snapshot is independent.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    snap_d  = snap_q;
    if (bus.load) begin
      if (lv_valid) begin
        count_d = bus.load_val;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.en) begin
      carry_d = boundary;
      // In saturate mode the boundary value simply holds.
      if (WRAP || !boundary) begin
        count_d = bus.dir ? W'(step_up) : W'(step_dn);
      end
    end
    if (bus.upd) begin
      snap_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      snap_q  <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      snap_q  <= snap_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.snap     = snap_q;
  assign bus.carry    = carry_q;
  assign bus.load_err = err_q;

endmodule
